corevx_loadunit: RTL and testbench

Memory-stage load sequencer for the corevx core. Accepts a load request from execute, checks alignment, performs one word-aligned read on the data bus with a req/ack handshake, and registers the raw word, byte offset and load type for the combinational load data generator downstream, which performs the shift and sign-extension. It flags misaligned, unknown-type, bus-error and (optionally) timed-out loads.

---
 rtl/corevx_loadunit.sv | 135 +++++++++++++
 tb/tb_corevx_loadunit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/corevx_loadunit.sv
// Memory-stage load sequencer: alignment check, one word-aligned bus read, registered result.
// Optional bus watchdog enabled by defining COREVX_LOADUNIT_TIMEOUT_EN.
module corevx_loadunit #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        LoadReq,
  input  logic [31:0] LoadAddr,
  input  logic [2:0]  LoadType,
  input  logic        LoadKill,
  output logic        LoadBusy,
  output logic        LoadDone,
  output logic [31:0] LoadData,
  output logic [1:0]  LoadOffset,
  output logic [2:0]  LoadTypeOut,
  output logic        LoadMissaligned,
  output logic        LoadUnknownType,
  output logic        LoadError,
  output logic        LoadTimeout,
  output logic [31:0] BusAddress,
  output logic        BusRead,
  input  logic        BusAck,
  input  logic [31:0] BusReadData,
  input  logic        BusError
);

  localparam logic [2:0] LOAD_WORD          = 3'd0;
  localparam logic [2:0] LOAD_HALF          = 3'd1;
  localparam logic [2:0] LOAD_HALF_UNSIGNED = 3'd2;
  localparam logic [2:0] LOAD_BYTE          = 3'd3;
  localparam logic [2:0] LOAD_BYTE_UNSIGNED = 3'd4;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t state, state_next;
  logic   killed;
  logic   miss_r, unk_r, err_r;
  logic   misaligned, unknown;
  logic   accept;
  logic   timeout_hit;

  always_comb begin
    misaligned = 1'b0;
    unknown    = 1'b0;
    case (LoadType)
      LOAD_WORD:                             misaligned = (LoadAddr[1:0] != 2'b00);
      LOAD_HALF, LOAD_HALF_UNSIGNED:         misaligned = LoadAddr[0];
      LOAD_BYTE, LOAD_BYTE_UNSIGNED:         misaligned = 1'b0;
      default:                               unknown    = 1'b1;
    endcase
  end

  assign accept = (state == IDLE) && LoadReq && !LoadKill;

`ifdef COREVX_LOADUNIT_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        tmo_r;

  // Counter sits at zero outside WAIT, so it is already clear on WAIT entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      tmo_r  <= 1'b0;
    end else begin
      if (state != WAIT)  wd_cnt <= '0;
      else if (!BusAck)   wd_cnt <= wd_cnt + 16'd1;
      if (accept)           tmo_r <= 1'b0;
      else if (timeout_hit) tmo_r <= 1'b1;
    end
  end

  assign timeout_hit = (state == WAIT) && !BusAck && (wd_cnt == 16'(TIMEOUT - 1));
  assign LoadTimeout = tmo_r & LoadDone;
`else
  assign timeout_hit = 1'b0;
  assign LoadTimeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (misaligned || unknown) ? DONE : WAIT;
      WAIT:    if (BusAck || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      killed      <= 1'b0;
      miss_r      <= 1'b0;
      unk_r       <= 1'b0;
      err_r       <= 1'b0;
      LoadData    <= '0;
      LoadOffset  <= '0;
      LoadTypeOut <= '0;
      BusAddress  <= '0;
    end else begin
      if (accept) begin
        killed      <= 1'b0;
        miss_r      <= misaligned && !unknown;
        unk_r       <= unknown;
        err_r       <= 1'b0;
        LoadOffset  <= LoadAddr[1:0];
        LoadTypeOut <= LoadType;
        BusAddress  <= {LoadAddr[31:2], 2'b00};
      end
      if (state == WAIT) begin
        // Kill only suppresses reporting; the bus cycle runs to completion.
        if (LoadKill) killed <= 1'b1;
        if (BusAck) begin
          if (BusError) err_r    <= 1'b1;
          else          LoadData <= BusReadData;
        end else if (timeout_hit) begin
          err_r <= 1'b1;
        end
      end
    end
  end

  assign BusRead         = (state == WAIT);
  assign LoadBusy        = (state != IDLE);
  assign LoadDone        = (state == DONE) && !killed && !LoadKill;
  assign LoadMissaligned = miss_r & LoadDone;
  assign LoadUnknownType = unk_r & LoadDone;
  assign LoadError       = err_r & LoadDone;

endmodule

// File: tb/tb_corevx_loadunit.sv
// Scoreboard bench for corevx_loadunit; timeout scenario runs when COREVX_LOADUNIT_TIMEOUT_EN is defined.
module tb_corevx_loadunit;

  localparam logic [2:0] LOAD_WORD          = 3'd0;
  localparam logic [2:0] LOAD_HALF          = 3'd1;
  localparam logic [2:0] LOAD_HALF_UNSIGNED = 3'd2;
  localparam logic [2:0] LOAD_BYTE          = 3'd3;
  localparam logic [2:0] LOAD_BYTE_UNSIGNED = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        LoadReq = 1'b0;
  logic [31:0] LoadAddr = '0;
  logic [2:0]  LoadType = '0;
  logic        LoadKill = 1'b0;
  logic        LoadBusy, LoadDone;
  logic [31:0] LoadData;
  logic [1:0]  LoadOffset;
  logic [2:0]  LoadTypeOut;
  logic        LoadMissaligned, LoadUnknownType, LoadError, LoadTimeout;
  logic [31:0] BusAddress;
  logic        BusRead;
  logic        BusAck = 1'b0;
  logic [31:0] BusReadData = '0;
  logic        BusError = 1'b0;

  corevx_loadunit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .LoadReq(LoadReq), .LoadAddr(LoadAddr), .LoadType(LoadType),
    .LoadKill(LoadKill), .LoadBusy(LoadBusy), .LoadDone(LoadDone), .LoadData(LoadData),
    .LoadOffset(LoadOffset), .LoadTypeOut(LoadTypeOut), .LoadMissaligned(LoadMissaligned),
    .LoadUnknownType(LoadUnknownType), .LoadError(LoadError), .LoadTimeout(LoadTimeout),
    .BusAddress(BusAddress), .BusRead(BusRead), .BusAck(BusAck), .BusReadData(BusReadData),
    .BusError(BusError)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  off;
    logic [2:0]  typ;
    logic [3:0]  flags;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Independent alignment model: returns {misaligned, unknown}.
  function automatic logic [1:0] model_flags(input logic [2:0] typ, input logic [1:0] off);
    case (typ)
      LOAD_WORD:                     return {off != 2'b00, 1'b0};
      LOAD_HALF, LOAD_HALF_UNSIGNED: return {off[0], 1'b0};
      LOAD_BYTE, LOAD_BYTE_UNSIGNED: return 2'b00;
      default:                       return 2'b01;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && LoadDone) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(LoadDone), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_data", LoadData, e.data);
        chk("sb_offset", 32'(LoadOffset), 32'(e.off));
        chk("sb_type", 32'(LoadTypeOut), 32'(e.typ));
        chk("sb_flags", 32'({LoadMissaligned, LoadUnknownType, LoadError, LoadTimeout}), 32'(e.flags));
      end
    end
  end

  task automatic wait_idle();
    int g = 0;
    while (LoadBusy && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    if (LoadBusy) chk("idle_wait_expired", 32'(LoadBusy), 32'd0);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [2:0] typ, input int delay,
                         input bit err, input logic [31:0] data, input bit kill);
    logic [1:0] mf;
    bit         bus;
    exp_t       e;
    mf  = model_flags(typ, addr[1:0]);
    bus = (mf == 2'b00);
    wait_idle();
    e.off   = addr[1:0];
    e.typ   = typ;
    e.data  = (bus && !err) ? data : last_data;
    e.flags = {mf, bus && err, 1'b0};
    if (!kill) sb.push_back(e);
    if (bus && !err) last_data = data;
    LoadReq = 1'b1; LoadAddr = addr; LoadType = typ;
    @(posedge clk); #1;
    LoadReq = 1'b0;
    if (!bus) begin
      chk("nobus_read", 32'(BusRead), 32'd0);
      chk("nobus_done", 32'(LoadDone), 32'd1);
    end else begin
      chk("bus_read", 32'(BusRead), 32'd1);
      chk("bus_addr", BusAddress, {addr[31:2], 2'b00});
      if (kill) LoadKill = 1'b1;
      repeat (delay - 1) begin
        @(posedge clk); #1;
        LoadKill = 1'b0;
        chk("read_held", 32'(BusRead), 32'd1);
      end
      BusAck = 1'b1; BusError = err; BusReadData = data;
      @(posedge clk); #1;
      BusAck = 1'b0; BusError = 1'b0; LoadKill = 1'b0;
      chk("read_drop", 32'(BusRead), 32'd0);
      chk("done_pulse", 32'(LoadDone), kill ? 32'd0 : 32'd1);
      chk("busy_in_done", 32'(LoadBusy), 32'd1);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(LoadDone), 32'd0);
    chk("busy_after_done", 32'(LoadBusy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(LoadBusy), 32'd0);
    chk("rst_busread", 32'(BusRead), 32'd0);
    chk("rst_done", 32'(LoadDone), 32'd0);
    chk("rst_data", LoadData, 32'd0);
    chk("rst_addr", BusAddress, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_load(32'h0000_1000, LOAD_WORD,          3, 1'b0, 32'hDEAD_BEEF, 1'b0);
    do_load(32'h0000_2000, LOAD_WORD,          2, 1'b1, 32'h5555_5555, 1'b0);
    do_load(32'h0000_1003, LOAD_HALF,          1, 1'b0, 32'h0,         1'b0);
    do_load(32'h0000_1002, LOAD_WORD,          1, 1'b0, 32'h0,         1'b0);
    do_load(32'h0000_1000, 3'b111,             1, 1'b0, 32'h0,         1'b0);
    do_load(32'h0000_1003, LOAD_BYTE,          1, 1'b0, 32'h1122_3344, 1'b0);
    do_load(32'h0000_2002, LOAD_HALF_UNSIGNED, 1, 1'b0, 32'hA5A5_0F0F, 1'b0);
    do_load(32'h0000_3001, LOAD_BYTE_UNSIGNED, 2, 1'b0, 32'h0BAD_F00D, 1'b0);
    do_load(32'h0000_3000, LOAD_WORD,          2, 1'b0, 32'hCAFE_0001, 1'b1);
    do_load(32'h0000_4004, LOAD_WORD,          1, 1'b0, 32'h1234_5678, 1'b0);

    // Acks while idle must not produce a completion.
    BusAck = 1'b1; BusReadData = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    BusAck = 1'b0;
    chk("idle_ack_data", LoadData, last_data);
    chk("idle_ack_busy", 32'(LoadBusy), 32'd0);

`ifdef COREVX_LOADUNIT_TIMEOUT_EN
    begin
      exp_t e;
      int   cnt;
      e.data = last_data; e.off = 2'b00; e.typ = LOAD_WORD; e.flags = 4'b0011;
      sb.push_back(e);
      LoadReq = 1'b1; LoadAddr = 32'h0000_5000; LoadType = LOAD_WORD;
      @(posedge clk); #1;
      LoadReq = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
        if (!BusRead) break;
        cnt++;
        @(posedge clk); #1;
      end
      chk("timeout_read_cycles", 32'(cnt), 32'd4);
      chk("timeout_done", 32'(LoadDone), 32'd1);
      @(posedge clk); #1;
    end
`endif

    // Reset while waiting on the bus.
    LoadReq = 1'b1; LoadAddr = 32'h0000_6002; LoadType = LOAD_HALF;
    @(posedge clk); #1;
    LoadReq = 1'b0;
    chk("prerst_read", 32'(BusRead), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("wrst_read", 32'(BusRead), 32'd0);
    chk("wrst_busy", 32'(LoadBusy), 32'd0);
    chk("wrst_data", LoadData, 32'd0);
    chk("wrst_offset", 32'(LoadOffset), 32'd0);
    chk("wrst_type", 32'(LoadTypeOut), 32'd0);
    chk("wrst_addr", BusAddress, 32'd0);
    rst = 1'b0;
    last_data = '0;
    @(posedge clk); #1;

    do_load(32'h0000_7000, LOAD_WORD, 1, 1'b0, 32'h0F0F_F0F0, 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
